// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: shared mat_mul defaults, scheduler state encoding and latency helper.
package mat_mul_pkg;
    localparam int N_DEF      = 2;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_e;

    function automatic int mm_latency(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog: reloadable down-counter; expired marks TIMEOUT-1 idle cycles since the last reload.
module sched_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = reload ? W'(TIMEOUT - 1) : (cnt_q > W'(1) ? cnt_q - W'(1) : cnt_q);
        expired = (cnt_q == W'(1)) && !reload;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= W'(TIMEOUT - 1);
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mat_mul_tile_sched.sv
// mat_mul_tile_sched: clears mat_mul, streams num_k tile pairs from tile memory,
// then waits for every product to be accumulated before pulsing done.
module mat_mul_tile_sched
    import mat_mul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int K_W     = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [K_W-1:0]    cfg_num_k,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              mm_valid_in,
    output logic              mm_resetn,
    input  logic              mm_valid_out
);
    localparam int MM_LAT = mm_latency(N);
    localparam int CW     = K_W + 1;
    // never let the watchdog be shorter than the mat_mul pipeline itself
    localparam int WD_T   = (TIMEOUT > MM_LAT + 1) ? TIMEOUT : MM_LAT + 1;

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [K_W-1:0]    num_k_q, num_k_d;
    logic [CW-1:0]     issue_q, issue_d;
    logic [CW-1:0]     recv_q, recv_d;
    logic              error_q, error_d;
    logic              mm_valid_in_q;
    logic              wd_expired;

    sched_watchdog #(.TIMEOUT(WD_T)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .reload ((state_q != S_DRAIN) || mm_valid_out),
        .expired(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_k_d = num_k_q;
        issue_d = issue_q;
        recv_d  = recv_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: if (start) begin
                base_d  = cfg_base;
                num_k_d = cfg_num_k;
                issue_d = '0;
                recv_d  = '0;
                error_d = 1'b0;
                state_d = S_CLEAR;
            end
            S_CLEAR: state_d = (num_k_q != '0) ? S_ISSUE : S_DONE;
            S_ISSUE: begin
                issue_d = issue_q + CW'(1);
                recv_d  = recv_q + CW'(mm_valid_out);
                if (issue_q + CW'(1) == CW'(num_k_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                recv_d = recv_q + CW'(mm_valid_out);
                if (recv_q == CW'(num_k_q)) state_d = S_DONE;
                else if (wd_expired) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            num_k_q       <= '0;
            issue_q       <= '0;
            recv_q        <= '0;
            error_q       <= 1'b0;
            mm_valid_in_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            num_k_q       <= num_k_d;
            issue_q       <= issue_d;
            recv_q        <= recv_d;
            error_q       <= error_d;
            mm_valid_in_q <= rd_en;
        end
    end

    // memory data arrives one cycle after rd_en, so valid_in is rd_en registered
    always_comb begin
        busy        = state_q != S_IDLE;
        done        = state_q == S_DONE;
        error       = error_q;
        rd_en       = state_q == S_ISSUE;
        rd_addr     = base_q + ADDR_W'(issue_q);
        mm_valid_in = mm_valid_in_q;
        mm_resetn   = !reset && (state_q != S_CLEAR);
    end
endmodule

// File: tb/tb_mat_mul_tile_sched.sv
// tb_mat_mul_tile_sched: table-driven and random jobs against a tile memory plus a 2x2
// accumulating mat_mul stub; expectations come from plain matrix arithmetic and latency formulas.
module tb_mat_mul_tile_sched;
    localparam int TIMEOUT = 16;
    localparam int MM_LAT  = 2;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [9:0] cfg_base = '0;
    logic [7:0] cfg_num_k = '0;
    logic       busy, done, error, rd_en, mm_valid_in, mm_resetn, mm_valid_out;
    logic [9:0] rd_addr;

    int n_checks = 0, n_fail = 0;
    int a_mem[1024][4], b_mem[1024][4];
    int rd_a[4], rd_b[4], p1[4], p2[4], acc[4];
    logic v1 = 1'b0, v2 = 1'b0;
    int pcnt = 0, drop_idx = 0;
    bit drop_en = 1'b0;

    typedef struct {
        logic [9:0] base;
        int         k;
        int         lat;
        bit         spam;
        bit         use_model;
        int         r0, r1, r2, r3;
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    mat_mul_tile_sched #(.N(2), .ADDR_W(10), .K_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_num_k(cfg_num_k),
        .busy(busy), .done(done), .error(error), .rd_en(rd_en), .rd_addr(rd_addr),
        .mm_valid_in(mm_valid_in), .mm_resetn(mm_resetn), .mm_valid_out(mm_valid_out)
    );

    // tile memory (1-cycle read) and 2x2 mat_mul stub with MM_LAT=2 and optional dropped pulse
    always @(posedge clk) begin
        if (rd_en) for (int i = 0; i < 4; i++) begin
            rd_a[i] <= a_mem[rd_addr][i];
            rd_b[i] <= b_mem[rd_addr][i];
        end
        if (!mm_resetn) begin
            v1 <= 1'b0; v2 <= 1'b0; pcnt <= 0;
            for (int i = 0; i < 4; i++) acc[i] <= 0;
        end else begin
            v1 <= mm_valid_in;
            v2 <= v1;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    p1[i*2+j] <= rd_a[i*2]*rd_b[j] + rd_a[i*2+1]*rd_b[2+j];
            for (int i = 0; i < 4; i++) p2[i] <= p1[i];
            if (v2) begin
                pcnt <= pcnt + 1;
                for (int i = 0; i < 4; i++) acc[i] <= acc[i] + p2[i];
            end
        end
    end
    assign mm_valid_out = v2 && !(drop_en && pcnt == drop_idx);

    function automatic int ref_el(input logic [9:0] base, input int k, input int e);
        int s, r, c, ad;
        s = 0; r = e / 2; c = e % 2;
        for (int i = 0; i < k; i++) begin
            ad = (int'(base) + i) % 1024;
            s += a_mem[ad][r*2]*b_mem[ad][c] + a_mem[ad][r*2+1]*b_mem[ad][2+c];
        end
        return s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // lat<0 means a watchdog finish: done must follow the last pulse by TIMEOUT cycles
    task automatic run_job(input logic [9:0] base, input int k, input int lat, input bit exp_err,
                           input bit spam, input bit use_model, input int r0, r1, r2, r3);
        int done_at, first_rd, last_rd, last_pulse, busy_cnt, rstn_low, done_cnt;
        int r[4];
        logic [9:0] addrs[$];
        r = '{r0, r1, r2, r3};
        done_at = -1; first_rd = -1; last_rd = -1; last_pulse = -1;
        busy_cnt = 0; rstn_low = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1; cfg_base = base; cfg_num_k = 8'(k);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (rd_en) begin
                addrs.push_back(rd_addr);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (!mm_resetn) rstn_low++;
            if (busy) busy_cnt++;
            if (mm_valid_out) last_pulse = cyc;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                    chk("error_at_done", error, exp_err);
                    if (!exp_err)
                        for (int e = 0; e < 4; e++)
                            chk("result", acc[e], use_model ? ref_el(base, k, e) : r[e]);
                end
            end
            start = (spam && done_at < 0 && cyc < lat - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (spam && done_at < 0) cfg_base = 10'($urandom);
            if (done_at >= 0 && (!spam || cyc >= done_at + 3)) break;
        end
        if (done_at < 0) chk("done_seen", 0, 1);
        else begin
            if (lat > 0) chk("done_latency", done_at, lat);
            else chk("timeout_gap", done_at - last_pulse, TIMEOUT);
            chk("busy_cycles", busy_cnt, done_at);
            chk("clear_cycles", rstn_low, 1);
            if (spam) chk("done_pulses", done_cnt, 1);
        end
        chk("num_reads", addrs.size(), k);
        for (int i = 0; i < addrs.size(); i++) chk("rd_addr", addrs[i], (int'(base) + i) % 1024);
        if (k > 0) chk("rd_contiguous", last_rd - first_rd, k - 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int dn;
        for (int a = 0; a < 1024; a++)
            for (int e = 0; e < 4; e++) begin
                a_mem[a][e] = int'($urandom_range(0, 15)) - 8;
                b_mem[a][e] = int'($urandom_range(0, 15)) - 8;
            end
        for (int i = 0; i < 3; i++) begin
            a_mem[16+i] = '{1, 0, 0, 1};
            b_mem[16+i] = '{(i+1)*1, (i+1)*2, (i+1)*3, (i+1)*4};
        end
        a_mem[32] = '{-1, 2, 3, -4};
        b_mem[32] = '{-1, 2, 3, -4};

        tbl[0] = '{10'h010, 3, 9,  1'b0, 1'b0, 6, 12, 18, 24};
        tbl[1] = '{10'h020, 1, 7,  1'b0, 1'b0, 7, -10, -15, 22};
        tbl[2] = '{10'h200, 0, 2,  1'b0, 1'b0, 0, 0, 0, 0};
        tbl[3] = '{10'h3FE, 4, 10, 1'b1, 1'b1, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_mm_valid_in", mm_valid_in, 0);
        chk("rst_mm_resetn", mm_resetn, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_mm_resetn", mm_resetn, 1);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++)
            run_job(tbl[i].base, tbl[i].k, tbl[i].lat, 1'b0, tbl[i].spam, tbl[i].use_model,
                    tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].r3);

        drop_en = 1'b1; drop_idx = 1;
        run_job(10'h050, 2, -1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
        drop_en = 1'b0;
        @(negedge clk);
        chk("error_sticky", error, 1);
        run_job(10'h060, 3, 9, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

        @(negedge clk);
        start = 1'b1; cfg_base = 10'h100; cfg_num_k = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_issue", rd_en, 1);
        reset = 1'b1;
        #1;
        chk("abort_mm_resetn", mm_resetn, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_done", done, 0);
        chk("abort_mm_valid_in", mm_valid_in, 0);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        run_job(10'h100, 5, 11, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

        for (int j = 0; j < 6; j++) begin
            int k;
            k = int'($urandom_range(0, 6));
            run_job(10'($urandom), k, (k == 0) ? 2 : k + 4 + MM_LAT, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mat_mul_tile_sched.md
Name: mat_mul_tile_sched

Overview:
- Job controller that sequences one tiled accumulation on a single mat_mul instance (N×N, accumulating result register).
- For each job it clears the mat_mul accumulator, then streams num_k tile pairs (A_k, B_k) from a 1-cycle-latency tile memory into mat_mul.
- It counts mat_mul's valid_out pulses until all products have been accumulated, then signals done; result = Σ A_k·B_k.
- Sits between the SIMD instruction decoder (start/cfg) and the tile buffer + mat_mul datapath.

Parameters:
- N, 2, matrix dimension passed through to mat_mul; sets pipeline latency.
- ADDR_W, 10, tile-memory address width; one address holds one (A_k, B_k) pair.
- K_W, 8, width of the tile-count field.
- TIMEOUT, 16, maximum cycles DRAIN waits between valid_out pulses before flagging an error.
- MM_LAT, $clog2(N)+1, localparam: cycles from mm_valid_in to mm_valid_out.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- cfg_base  in  ADDR_W  tile-memory address of the first pair
- cfg_num_k  in  K_W  number of tile pairs to accumulate
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job completes
- error  out  1  sticky drain-timeout flag; cleared by reset or the next accepted start
- rd_en  out  1  tile-memory read strobe
- rd_addr  out  ADDR_W  tile-memory read address
- mm_valid_in  out  1  drives mat_mul valid_in
- mm_resetn  out  1  drives mat_mul resetn (active-low accumulator clear)
- mm_valid_out  in  1  mat_mul valid_out

Behaviour:
- Reset values: busy=0, done=0, error=0, rd_en=0, rd_addr=0, mm_valid_in=0, mm_resetn=0. mm_resetn is held low for every cycle reset is high; state returns to IDLE.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches cfg_base and cfg_num_k, clears error and both counters, then moves to CLEAR.
  - start while busy has no effect. It is not queued.
- CLEAR (exactly 1 cycle):
  - mm_resetn=0, which zeroes the mat_mul result.
  - Next state is ISSUE if num_k≠0, otherwise DONE.
- ISSUE:
  - rd_en=1 and rd_addr=base+issue_cnt, one read per cycle with no bubbles. issue_cnt is incremented each cycle.
  - rd_addr wraps modulo 2^ADDR_W.
  - After num_k reads, move to DRAIN.
- mm_valid_in is rd_en delayed by one register stage, aligning it with the 1-cycle memory data. The tile data path itself bypasses this block.
- DRAIN:
  - Count mm_valid_out pulses in recv_cnt; mm_valid_out is also counted during ISSUE.
  - When recv_cnt==num_k, move to DONE.
  - A watchdog counter reloads on every pulse. If it reaches TIMEOUT with recv_cnt<num_k, set error=1 and move to DONE.
- DONE (1 cycle): done=1, then IDLE. The mat_mul result stays stable until the next CLEAR.
- mm_resetn=1 in every state except CLEAR and reset.
- Nominal latency from start to done, with num_k=K≥1: 1 (IDLE→CLEAR) + 1 (CLEAR) + K (ISSUE) + 1 (mem) + MM_LAT + 1 (DONE register).
  - With N=2 and K=3 this is 9 cycles.
- num_k=0: done is asserted 2 cycles after start, result=0, no reads issued.
- Counters are K_W+1 bits wide so num_k=2^K_W−1 does not overflow.
- A spurious mm_valid_out in IDLE, CLEAR or DONE is ignored.
- A reset asserted mid-job aborts the job immediately: no done pulse, and mm_resetn=0 for the duration of reset.

Decomposition:
- Package mat_mul_pkg holds:
  - the state enum (sched_state_e)
  - function mm_latency(N) = $clog2(N)+1
  - the shared defaults for N and ADDR_W, reused by mat_mul and this block.
- One sub-module, sched_watchdog: a reloadable down-counter with an expired output, parameterised by TIMEOUT.
- Address and receive counters stay inline.

Test Plan:
- N=2, base=0x010, num_k=3. Memory holds A_k=I, B_k=[[1,2],[3,4]]·k.
  - rd_addr must be 0x010, 0x011, 0x012 on consecutive cycles.
  - done must assert 9 cycles after start.
  - result must be [[6,12],[18,24]].
- num_k=0 → no rd_en, done 2 cycles after start, busy high for exactly 2 cycles, result [[0,0],[0,0]].
- Two back-to-back jobs, second with start in the cycle after done, A=B=[[-1,2],[3,-4]] and num_k=1.
  - Result must be [[7,-10],[-15,22]], with no carry-over from job 1.
  - mm_resetn must be low exactly 1 cycle per job.
- Stub mat_mul that drops the last mm_valid_out, num_k=2 → error=1 and done exactly TIMEOUT cycles after the last received pulse.
  - A following start clears error.
- Assert reset for 1 cycle during ISSUE of a num_k=5 job.
  - Next cycle: busy=0, rd_en=0, no done.
  - A subsequent start runs normally.
- base=0x3FE, num_k=4 → rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
  - start pulses during busy are ignored, with exactly one done pulse.
